// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 TDM multiplexer.
package mux_pkg;

    localparam int MUX_DATA_WIDTH = 8;
    localparam logic [MUX_DATA_WIDTH-1:0] MUX_IDLE_CHAR = 8'hBC;

    typedef logic [MUX_DATA_WIDTH-1:0] lane_word_t;

    // Keeps the lane index at least one bit wide.
    function automatic int lane_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_slot_counter.sv
// Free-running slot counter for the TDM multiplexer; wraps by natural modulo.
module mux_slot_counter
    import mux_pkg::*;
#(
    parameter  int NUM_LANES = 4,
    localparam int LW        = lane_idx_w(NUM_LANES)
) (
    input  logic          clk_4f,
    input  logic          reset,
    input  logic          enable,
    output logic [LW-1:0] slot,
    output logic          last_slot
);

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            slot <= '0;
        end else if (enable) begin
            slot <= slot + LW'(1);
        end
    end

    assign last_slot = (slot == LW'(NUM_LANES - 1));

endmodule

// File: rtl/mux_tdm_nto1.sv
// N:1 time-division multiplexer: captures all lanes once per frame, then emits one lane per clock.
// Build option: define MUX_IDLE_EN to fill invalid slots with IDLE_CHAR instead of zero.
module mux_tdm_nto1
    import mux_pkg::*;
#(
    parameter  int                    NUM_LANES  = 4,
    parameter  int                    DATA_WIDTH = MUX_DATA_WIDTH,
    parameter  logic [DATA_WIDTH-1:0] IDLE_CHAR  = DATA_WIDTH'(MUX_IDLE_CHAR),
    localparam int                    LW         = lane_idx_w(NUM_LANES)
) (
    input  logic                            clk_4f,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_LANES-1:0]            valid_in,
    output logic                            in_ready,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            valid_out,
    output logic [LW-1:0]                   lane_id,
    output logic                            frame_start
);

`ifdef MUX_IDLE_EN
    localparam bit IDLE_EN = 1'b1;
`else
    localparam bit IDLE_EN = 1'b0;
`endif

    localparam logic [DATA_WIDTH-1:0] FILL_WORD = IDLE_EN ? IDLE_CHAR : '0;

    logic [LW-1:0]         slot;
    logic                  last_slot;
    logic [DATA_WIDTH-1:0] hold [NUM_LANES];
    logic [NUM_LANES-1:0]  hold_valid;

    mux_slot_counter #(
        .NUM_LANES (NUM_LANES)
    ) u_slot_counter (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .enable    (enable),
        .slot      (slot),
        .last_slot (last_slot)
    );

    assign in_ready = enable && last_slot && !reset;

    // The capture edge also emits the previous hold[N-1]; non-blocking order makes that work.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                hold[i] <= '0;
            end
            hold_valid  <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            lane_id     <= '0;
            frame_start <= 1'b0;
        end else if (enable) begin
            data_out    <= hold_valid[slot] ? hold[slot] : FILL_WORD;
            valid_out   <= hold_valid[slot];
            lane_id     <= slot;
            frame_start <= (slot == '0);
            if (last_slot) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    hold[i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
                hold_valid <= valid_in;
            end
        end
    end

endmodule

// File: tb/tb_mux_tdm_nto1.sv
// Bench for mux_tdm_nto1 (4 lanes x 8 bits): directed scenarios plus random traffic against a word-queue model.
module tb_mux_tdm_nto1;

    localparam int N  = 4;
    localparam int DW = 8;

`ifdef MUX_IDLE_EN
    localparam logic [DW-1:0] FILL = 8'hBC;
`else
    localparam logic [DW-1:0] FILL = 8'h00;
`endif

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
    } word_t;

    logic          clk_4f = 1'b0;
    logic          reset;
    logic          enable;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]  valid_in;
    logic          in_ready;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [1:0]    lane_id;
    logic          frame_start;

    mux_tdm_nto1 #(.NUM_LANES(N), .DATA_WIDTH(DW)) dut (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .enable      (enable),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .in_ready    (in_ready),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .lane_id     (lane_id),
        .frame_start (frame_start)
    );

    always #5 clk_4f = ~clk_4f;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of words still to be emitted, plus a count of enabled cycles.
    word_t         pending [$];
    int            en_cycles = 0;
    bit            model_live = 0;
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    logic [1:0]    exp_lane;
    logic          exp_fs;
    logic          last_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [N*DW-1:0] d, input logic [N-1:0] v);
        word_t w;
        if (r) begin
            pending.delete();
            for (int i = 0; i < N; i++) begin
                w.v = 1'b0;
                w.d = '0;
                pending.push_back(w);
            end
            en_cycles  = 0;
            exp_data   = '0;
            exp_valid  = 1'b0;
            exp_lane   = '0;
            exp_fs     = 1'b0;
            model_live = 1;
        end else if (e && model_live) begin
            w = pending.pop_front();
            exp_data  = w.v ? w.d : FILL;
            exp_valid = w.v;
            exp_lane  = 2'(en_cycles % N);
            exp_fs    = (en_cycles % N) == 0;
            if ((en_cycles % N) == N - 1) begin
                for (int i = 0; i < N; i++) begin
                    w.v = v[i];
                    w.d = d[i*DW +: DW];
                    pending.push_back(w);
                end
            end
            en_cycles++;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [N*DW-1:0] d, input logic [N-1:0] v);
        reset    = r;
        enable   = e;
        data_in  = d;
        valid_in = v;
        #1;
        last_ready = in_ready;
        if (model_live)
            chk("in_ready", 32'(in_ready), 32'(e && !r && ((en_cycles % N) == N - 1)));
        @(posedge clk_4f);
        model_edge(r, e, d, v);
        @(negedge clk_4f);
        chk("data_out", 32'(data_out), 32'(exp_data));
        chk("valid_out", 32'(valid_out), 32'(exp_valid));
        chk("lane_id", 32'(lane_id), 32'(exp_lane));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
    endtask

    localparam logic [N*DW-1:0] FRAME_A = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    localparam logic [N*DW-1:0] FRAME_B = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    localparam logic [N*DW-1:0] FRAME_C = {8'h13, 8'h12, 8'h11, 8'h10};

    initial begin
        int first_ready;
        logic [N*DW-1:0] rd;
        reset = 1'b1; enable = 1'b0; data_in = '0; valid_in = '0;
        @(negedge clk_4f);

        // Reset held for 3 cycles, then release: in_ready must first rise in the 4th cycle.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, FRAME_A, 4'hF);
        first_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, FRAME_A, 4'hF);
            if (last_ready && first_ready == 0) first_ready = i;
        end
        chk("first_in_ready_cycle", 32'(first_ready), 32'd4);

        // Frame A emitted, frame C (partial valid) captured at the end of it.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, FRAME_C, 4'b1010);
        chk("frameA_lane3_data", 32'(data_out), 32'hA3);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, FRAME_A, 4'hF);
        chk("frameC_lane1_data", 32'(data_out), 32'h11);

        // Stall two cycles with lane 1 on the output.
        step(1'b0, 1'b0, FRAME_A, 4'hF);
        step(1'b0, 1'b0, FRAME_A, 4'hF);
        chk("stall_hold", 32'(data_out), 32'h11);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, FRAME_A, 4'hF);

        // Frame A now on the output; reset while lane 2 is shown.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, FRAME_B, 4'hF);
        chk("pre_reset_lane2", 32'(data_out), 32'hA2);
        step(1'b1, 1'b1, FRAME_B, 4'hF);
        chk("post_reset_data", 32'(data_out), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, FRAME_A, 4'hF);
            chk("post_reset_invalid", 32'(valid_out), 32'h0);
        end

        // Back-to-back frames A then B.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, FRAME_B, 4'hF);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, FRAME_A, 4'hF);
        chk("b2b_last_B", 32'(data_out), 32'hB3);

        // Random traffic with occasional stalls and resets.
        for (int i = 0; i < 400; i++) begin
            rd = {$urandom(), $urandom()} >> 0;
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                 rd, 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
